riscv_pipe_hart: RTL and testbench
==================================

# riscv_pipe_hart

Parametrised successor to the single-issue RISC-V hart. It is a 4-stage in-order RV32I integer pipeline (ID, EX, MA, WB) fed by an external combinational instruction memory, and it adds three things the first hart lacks:

- full operand forwarding with load-use stall,
- branch/jump resolution in EX with a single-bubble squash,
- byte-lane loads and stores.

It sits between the instruction ROM and the data RAM, exactly as the first hart does.

## Interface
- XLEN, 32, datapath width; only 32 is legal, and elaboration fails otherwise.
- REGN, 32, architectural register count; 16 (RV32E) or 32.
- RESET_PC, 0, fetch address after reset.

Clock and reset: one clock; reset is asynchronous and active-high.

- rst  in  1  asynchronous active-high reset.
- clk  in  1  rising-edge clock.
- instruction  in  32  instruction at `pc`, valid combinationally in the same cycle.
- pc  out  XLEN  fetch address; reset RESET_PC.
- mem_read  in  XLEN  data RAM read word, combinational on `mem_addr`.
- mem_addr  out  XLEN  word-aligned data address (bits [1:0] forced 0); reset 0.
- mem_data  out  XLEN  store data, replicated across lanes; reset 0.
- mem_strb  out  XLEN/8  byte write enables; reset 0.
- mem_write  out  1  store strobe; reset 0.
- mem_ren  out  1  load strobe; reset 0.

## Operation
- **ID:** decodes `instruction` and reads the register file.
  - Register-file read is write-through: a WB write in the same cycle is seen.
  - x0 always reads 0.
- **ID latches:** pc, operands, immediate, rd, funct3, funct7[5], and op class into EX.
- **EX operand select, per rs1/rs2 (priority order):**
  1. MA (non-load producer, rd≠0, rd match).
  2. WB (`wb_result`, rd match).
  3. Latched value.
- **EX ALU:**
  - funct7[5] selects SUB for OP only, and SRA for both OP and OP_IMM.
  - Shift amount is the low 5 bits.
- **EX branch/jump:**
  - Branches compute BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - JAL target = pc+imm; JALR target = (rs1+imm) & ~1.
  - JAL/JALR write rd = pc+4; AUIPC writes pc+imm; LUI writes imm.
- **Redirect:** a taken branch or jump in EX loads `pc` with the target and converts the ID instruction into a bubble. Taken penalty is 1 cycle; not-taken penalty is 0.
- **Load-use stall:**
  - Condition: EX consumes an rd held by a load in MA.
  - Action: `pc`, ID and EX hold, and a bubble enters MA.
  - Stall has priority over redirect; a stalled branch resolves on the next cycle.
- **MA outputs:** MA registers the memory outputs.
  - Store:
    - `mem_write`=1 and `mem_data`=rs2 lane-replicated.
    - `mem_strb`: SB = 1<<a[1:0]; SH = 3<<{a[1],0}; SW = 4'hF.
  - Load: `mem_ren`=1 and `mem_strb`=0.
  - Otherwise all memory outputs are 0.
  - Misaligned accesses use the naturally aligned lane; no trap is taken.
- **WB:**
  - Loads: selects the lane of `mem_read` using the saved addr[1:0] and funct3, then sign- or zero-extends it (LB/LH/LW/LBU/LHU).
  - Writes rd at the clock edge if rd≠0.
- **Other opcodes:**
  - MISC_MEM, SYSTEM, and unknown opcodes are NOPs.
  - Unknown funct3 on LOAD/STORE/BRANCH is a NOP.
- **Reset:**
  - `pc`=RESET_PC and every pipeline stage holds a bubble.
  - All registers clear to 0 and all memory outputs go to 0.
  - Reset mid-operation discards in-flight instructions, and no memory write is issued.

## Timing
- **Instruction at pc P:**
  - ID in cycle n, EX in n+1, MA in n+2.
  - Memory ports are driven and WB happens in n+3.
  - The register is visible to ID in n+3.
- **Producer-to-consumer distance, without loads:** zero stall at distances 1, 2, and 3+ (served by MA, WB, and the regfile respectively).
- **Load followed immediately by a user:** exactly 1 stall cycle; distance ≥2 is stall-free.
- **Memory writes:** RAM writes at the edge that ends cycle n+3 of the store.
- **Redirect timing:**
  - `pc` shows the target in the cycle after the branch is in EX.
  - The squashed instruction produces no rd write and no memory strobe.

## Test plan
- **Reset:** assert rst in mid-program with a store in MA.
  - During reset: pc=RESET_PC, mem_write=0, mem_strb=0.
  - After release: the first fetch is at RESET_PC and no spurious write occurs.
- **Forwarding, no stall:** addi x1,x0,5; addi x2,x1,3; add x3,x2,x1.
  - Result: x1=5, x2=8, x3=13.
  - pc steps by +4 every cycle.
- **Load-use:** sw x1,16(x0) with x1=5; lw x4,16(x0); addi x5,x4,1.
  - pc holds exactly one cycle.
  - Result: x4=5, x5=6.
- **Byte lanes:** x1=0x80; sb x1,3(x0).
  - Store cycle: mem_strb=4'b1000, mem_data=0x80808080.
  - RAM word 0x80000000 gives lb x6,3(x0) → x6=0xFFFFFF80 and lbu → 0x00000080.
  - sh x1,2(x0) → mem_strb=4'b1100.
- **Control flow:**
  - beq x0,x0,+8 at 0x20: pc sequence 0x20, 0x24, 0x28, and the instruction at 0x24 does not write rd.
  - jal x1,-16 at 0x40: x1=0x44 and next pc=0x30.
  - jalr x0,1(x2) with x2=0x100: pc=0x100.
- **ALU modes:** with x1=0x80000000 and x2=4:
  - sra x3,x1,x2 → x3=0xF8000000.
  - srl → 0x08000000.
  - sub x4,x2,x1 → 0x80000004.
  - slt x5,x1,x2 → 1; sltu → 0.

Source files
------------

// File: rtl/riscv_pipe_hart.sv
// riscv_pipe_hart: 4-stage RV32I pipeline (ID, EX, MA, WB) with full
// forwarding, load-use stall, EX-resolved control flow and byte lanes.
package riscv_pipe_hart_pkg;
   typedef enum logic [3:0] {
      C_NOP, C_ALU, C_ALUI, C_LUI, C_AUIPC,
      C_JAL, C_JALR, C_BR, C_LD, C_ST
   } cls_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_v;
      logic [31:0] rs2_v;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic        f7b;
      logic        use1;
      logic        use2;
      logic        we;
      cls_e        cls;
   } id_ex_t;

   typedef struct packed {
      logic        we;
      logic        ld;
      logic        st;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [31:0] res;
      logic [31:0] sd;
   } ex_ma_t;

   typedef struct packed {
      logic        we;
      logic        ld;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [1:0]  lo;
      logic [31:0] res;
   } ma_wb_t;
endpackage

module riscv_pipe_hart
   import riscv_pipe_hart_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter int          REGN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic              rst,
   input  logic              clk,
   input  logic [31:0]       instruction,
   output logic [XLEN-1:0]   pc,
   input  logic [XLEN-1:0]   mem_read,
   output logic [XLEN-1:0]   mem_addr,
   output logic [XLEN-1:0]   mem_data,
   output logic [XLEN/8-1:0] mem_strb,
   output logic              mem_write,
   output logic              mem_ren
);
   localparam int RW = $clog2(REGN);

   if (XLEN != 32) begin : g_xlen_bad
      $error("riscv_pipe_hart: XLEN must be 32");
   end
   if (REGN != 16 && REGN != 32) begin : g_regn_bad
      $error("riscv_pipe_hart: REGN must be 16 or 32");
   end

   logic [31:0] pc_q, pc_d;
   id_ex_t      ex_q, ex_d, id_v;
   ex_ma_t      ma_q, ma_d;
   ma_wb_t      wb_q, wb_d;
   logic [31:0] maddr_q, maddr_d, mdata_q, mdata_d;
   logic [3:0]  mstrb_q, mstrb_d;
   logic        mwr_q, mwr_d, mren_q, mren_d;
   logic [31:0] rf_q [REGN];
   logic [31:0] rf_d [REGN];

   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [4:0]  rs1, rs2, rdi;
   logic [31:0] rs1_rf, rs2_rf, wb_res, ld_v;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic [31:0] a, b, op2, alu, res, target, sum;
   logic        taken, jump, stall, redirect;

   assign opc = instruction[6:0];
   assign f3  = instruction[14:12];
   assign rs1 = instruction[19:15];
   assign rs2 = instruction[24:20];
   assign rdi = instruction[11:7];

   // Load lane extraction; halfwords use the naturally aligned lane
   always_comb begin
      byte_v = 8'(mem_read >> {wb_q.lo, 3'b000});
      half_v = 16'(mem_read >> {wb_q.lo[1], 4'b0000});
      case (wb_q.f3)
         3'd0:    ld_v = {{24{byte_v[7]}}, byte_v};
         3'd1:    ld_v = {{16{half_v[15]}}, half_v};
         3'd4:    ld_v = {24'b0, byte_v};
         3'd5:    ld_v = {16'b0, half_v};
         default: ld_v = mem_read;
      endcase
      wb_res = wb_q.ld ? ld_v : wb_q.res;
   end

   always_comb begin
      rs1_rf = '0;
      rs2_rf = '0;
      if (rs1 != 5'd0) begin
         if (wb_q.we && wb_q.rd == rs1) rs1_rf = wb_res;
         else if (32'(rs1) < REGN) rs1_rf = rf_q[rs1[RW-1:0]];
      end
      if (rs2 != 5'd0) begin
         if (wb_q.we && wb_q.rd == rs2) rs2_rf = wb_res;
         else if (32'(rs2) < REGN) rs2_rf = rf_q[rs2[RW-1:0]];
      end
   end

   always_comb begin
      id_v       = '0;
      id_v.pc    = pc_q;
      id_v.rs1   = rs1;
      id_v.rs2   = rs2;
      id_v.rs1_v = rs1_rf;
      id_v.rs2_v = rs2_rf;
      id_v.f3    = f3;
      id_v.f7b   = instruction[30];
      unique case (1'b1)
         opc == 7'h33: begin
            id_v.cls  = C_ALU;
            id_v.use1 = 1'b1;
            id_v.use2 = 1'b1;
            id_v.rd   = rdi;
         end
         opc == 7'h13: begin
            id_v.cls  = C_ALUI;
            id_v.imm  = {{20{instruction[31]}}, instruction[31:20]};
            id_v.use1 = 1'b1;
            id_v.rd   = rdi;
         end
         opc == 7'h37: begin
            id_v.cls = C_LUI;
            id_v.imm = {instruction[31:12], 12'b0};
            id_v.rd  = rdi;
         end
         opc == 7'h17: begin
            id_v.cls = C_AUIPC;
            id_v.imm = {instruction[31:12], 12'b0};
            id_v.rd  = rdi;
         end
         opc == 7'h6F: begin
            id_v.cls = C_JAL;
            id_v.imm = {{11{instruction[31]}}, instruction[31],
                        instruction[19:12], instruction[20],
                        instruction[30:21], 1'b0};
            id_v.rd  = rdi;
         end
         opc == 7'h67: begin
            id_v.cls  = C_JALR;
            id_v.imm  = {{20{instruction[31]}}, instruction[31:20]};
            id_v.use1 = 1'b1;
            id_v.rd   = rdi;
         end
         opc == 7'h63 && f3 != 3'd2 && f3 != 3'd3: begin
            id_v.cls  = C_BR;
            id_v.imm  = {{19{instruction[31]}}, instruction[31],
                         instruction[7], instruction[30:25],
                         instruction[11:8], 1'b0};
            id_v.use1 = 1'b1;
            id_v.use2 = 1'b1;
         end
         opc == 7'h03 && f3 != 3'd3 && f3 < 3'd6: begin
            id_v.cls  = C_LD;
            id_v.imm  = {{20{instruction[31]}}, instruction[31:20]};
            id_v.use1 = 1'b1;
            id_v.rd   = rdi;
         end
         opc == 7'h23 && f3 < 3'd3: begin
            id_v.cls  = C_ST;
            id_v.imm  = {{20{instruction[31]}}, instruction[31:25],
                         instruction[11:7]};
            id_v.use1 = 1'b1;
            id_v.use2 = 1'b1;
         end
         default: ;
      endcase
      id_v.we = id_v.rd != 5'd0;
   end

   // EX operands: MA (non-load) beats WB beats the latched value
   always_comb begin
      a = ex_q.rs1_v;
      b = ex_q.rs2_v;
      if (ma_q.we && !ma_q.ld && ma_q.rd == ex_q.rs1) a = ma_q.res;
      else if (wb_q.we && wb_q.rd == ex_q.rs1) a = wb_res;
      if (ma_q.we && !ma_q.ld && ma_q.rd == ex_q.rs2) b = ma_q.res;
      else if (wb_q.we && wb_q.rd == ex_q.rs2) b = wb_res;
   end

   always_comb begin
      op2 = (ex_q.cls == C_ALU) ? b : ex_q.imm;
      case (ex_q.f3)
         3'd0: alu = (ex_q.cls == C_ALU && ex_q.f7b) ? a - op2 : a + op2;
         3'd1: alu = a << op2[4:0];
         3'd2: alu = {31'b0, $signed(a) < $signed(op2)};
         3'd3: alu = {31'b0, a < op2};
         3'd4: alu = a ^ op2;
         3'd5: alu = ex_q.f7b ? 32'($signed(a) >>> op2[4:0])
                              : a >> op2[4:0];
         3'd6: alu = a | op2;
         default: alu = a & op2;
      endcase
      case (ex_q.f3)
         3'd0:    taken = a == b;
         3'd1:    taken = a != b;
         3'd4:    taken = $signed(a) < $signed(b);
         3'd5:    taken = $signed(a) >= $signed(b);
         3'd6:    taken = a < b;
         3'd7:    taken = a >= b;
         default: taken = 1'b0;
      endcase
      sum = a + ex_q.imm;
      case (ex_q.cls)
         C_LUI:        res = ex_q.imm;
         C_AUIPC:      res = ex_q.pc + ex_q.imm;
         C_JAL,
         C_JALR:       res = ex_q.pc + 32'd4;
         C_LD, C_ST:   res = sum;
         default:      res = alu;
      endcase
      target = (ex_q.cls == C_JALR) ? {sum[31:1], 1'b0}
                                    : ex_q.pc + ex_q.imm;
      jump = ex_q.cls == C_JAL || ex_q.cls == C_JALR ||
             (ex_q.cls == C_BR && taken);
   end

   assign stall = ma_q.ld && ma_q.we &&
                  ((ex_q.use1 && ex_q.rs1 == ma_q.rd) ||
                   (ex_q.use2 && ex_q.rs2 == ma_q.rd));
   assign redirect = jump && !stall;

   always_comb begin
      pc_d     = pc_q + 32'd4;
      ex_d     = id_v;
      ma_d     = '0;
      ma_d.we  = ex_q.we;
      ma_d.ld  = ex_q.cls == C_LD;
      ma_d.st  = ex_q.cls == C_ST;
      ma_d.rd  = ex_q.rd;
      ma_d.f3  = ex_q.f3;
      ma_d.res = res;
      ma_d.sd  = b;
      if (stall) begin
         // Held EX keeps operands that WB is about to retire
         pc_d       = pc_q;
         ex_d       = ex_q;
         ex_d.rs1_v = a;
         ex_d.rs2_v = b;
         ma_d       = '0;
      end else if (redirect) begin
         pc_d = target;
         ex_d = '0;
      end
   end

   always_comb begin
      wb_d     = '0;
      wb_d.we  = ma_q.we;
      wb_d.ld  = ma_q.ld;
      wb_d.rd  = ma_q.rd;
      wb_d.f3  = ma_q.f3;
      wb_d.lo  = ma_q.res[1:0];
      wb_d.res = ma_q.res;
      maddr_d  = '0;
      mdata_d  = '0;
      mstrb_d  = '0;
      mwr_d    = 1'b0;
      mren_d   = 1'b0;
      if (ma_q.st) begin
         maddr_d = {ma_q.res[31:2], 2'b00};
         mwr_d   = 1'b1;
         case (ma_q.f3[1:0])
            2'd0: begin
               mdata_d = {4{ma_q.sd[7:0]}};
               mstrb_d = 4'b0001 << ma_q.res[1:0];
            end
            2'd1: begin
               mdata_d = {2{ma_q.sd[15:0]}};
               mstrb_d = 4'b0011 << {ma_q.res[1], 1'b0};
            end
            default: begin
               mdata_d = ma_q.sd;
               mstrb_d = 4'hF;
            end
         endcase
      end else if (ma_q.ld) begin
         maddr_d = {ma_q.res[31:2], 2'b00};
         mren_d  = 1'b1;
      end
   end

   always_comb begin
      rf_d = rf_q;
      if (wb_q.we && 32'(wb_q.rd) < REGN) rf_d[wb_q.rd[RW-1:0]] = wb_res;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         ex_q    <= '0;
         ma_q    <= '0;
         wb_q    <= '0;
         maddr_q <= '0;
         mdata_q <= '0;
         mstrb_q <= '0;
         mwr_q   <= 1'b0;
         mren_q  <= 1'b0;
         for (int i = 0; i < REGN; i++) rf_q[i] <= '0;
      end else begin
         pc_q    <= pc_d;
         ex_q    <= ex_d;
         ma_q    <= ma_d;
         wb_q    <= wb_d;
         maddr_q <= maddr_d;
         mdata_q <= mdata_d;
         mstrb_q <= mstrb_d;
         mwr_q   <= mwr_d;
         mren_q  <= mren_d;
         rf_q    <= rf_d;
      end
   end

   assign pc        = pc_q;
   assign mem_addr  = maddr_q;
   assign mem_data  = mdata_q;
   assign mem_strb  = mstrb_q;
   assign mem_write = mwr_q;
   assign mem_ren   = mren_q;
endmodule

// File: tb/tb_riscv_pipe_hart.sv
// Directed bench for riscv_pipe_hart: ROM/RAM models, per-cycle pc and
// memory-port checks, register results observed through stores.
module tb_riscv_pipe_hart;
   logic        rst, clk, clr;
   logic [31:0] instruction, pc, mem_read, mem_addr, mem_data;
   logic [3:0]  mem_strb;
   logic        mem_write, mem_ren, wr_seen;
   logic [31:0] imem [128];
   logic [31:0] ram [64];
   int          checks, failures;

   localparam logic [31:0] NOP = 32'h0000_0013;

   riscv_pipe_hart dut (
      .rst(rst), .clk(clk), .instruction(instruction), .pc(pc),
      .mem_read(mem_read), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_strb(mem_strb), .mem_write(mem_write), .mem_ren(mem_ren)
   );

   assign instruction = imem[pc[8:2]];
   assign mem_read    = ram[mem_addr[7:2]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < 64; i++) ram[i] <= '0;
      end else if (mem_write) begin
         for (int l = 0; l < 4; l++)
            if (mem_strb[l])
               ram[mem_addr[7:2]][8*l +: 8] <= mem_data[8*l +: 8];
      end
   end

   function automatic logic [31:0] e_i(int imm, int rs1, int f3, int rd,
                                       logic [6:0] op);
      logic [31:0] v;
      v = 32'(imm);
      return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction
   function automatic logic [31:0] e_r(int f7, int rs2, int rs1, int f3,
                                       int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
   endfunction
   function automatic logic [31:0] e_s(int imm, int rs2, int rs1, int f3);
      logic [31:0] v;
      v = 32'(imm);
      return {v[11:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:0], 7'h23};
   endfunction
   function automatic logic [31:0] e_b(int imm, int rs2, int rs1, int f3);
      logic [31:0] v;
      v = 32'(imm);
      return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11],
              7'h63};
   endfunction
   function automatic logic [31:0] e_j(int imm, int rd);
      logic [31:0] v;
      v = 32'(imm);
      return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_imem();
      for (int i = 0; i < 128; i++) imem[i] = NOP;
   endtask

   task automatic start();
      rst = 1'b1;
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      rst = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      clr      = 1'b1;
      clear_imem();
      tick(2);
      chk("reset_pc", pc, 32'h0);
      chk("reset_wr", 32'(mem_write), 32'h0);
      chk("reset_strb", 32'(mem_strb), 32'h0);
      chk("reset_ren", 32'(mem_ren), 32'h0);
      chk("reset_addr", mem_addr, 32'h0);

      // forwarding distances 1, 2 and 3
      clear_imem();
      imem[0] = e_i(5, 0, 0, 1, 7'h13);
      imem[1] = e_i(3, 1, 0, 2, 7'h13);
      imem[2] = e_r(0, 1, 2, 0, 3);
      imem[3] = e_s(0, 1, 0, 2);
      imem[4] = e_s(4, 2, 0, 2);
      imem[5] = e_s(8, 3, 0, 2);
      start();
      for (int c = 0; c < 6; c++) begin
         chk("fwd_pc", pc, 32'(4 * c));
         tick(1);
      end
      tick(6);
      chk("fwd_x1", ram[0], 32'd5);
      chk("fwd_x2", ram[1], 32'd8);
      chk("fwd_x3", ram[2], 32'd13);

      // load-use stall
      clear_imem();
      imem[0] = e_i(5, 0, 0, 1, 7'h13);
      imem[1] = e_s(16, 1, 0, 2);
      imem[2] = e_i(16, 0, 2, 4, 7'h03);
      imem[3] = e_i(1, 4, 0, 5, 7'h13);
      imem[4] = e_s(20, 4, 0, 2);
      imem[5] = e_s(24, 5, 0, 2);
      start();
      tick(3);
      chk("lu_pc3", pc, 32'd12);
      tick(1);
      chk("lu_pc4", pc, 32'd16);
      tick(1);
      chk("lu_pc5_hold", pc, 32'd16);
      chk("lu_ren", 32'(mem_ren), 32'h1);
      chk("lu_raddr", mem_addr, 32'd16);
      chk("lu_rstrb", 32'(mem_strb), 32'h0);
      tick(1);
      chk("lu_pc6", pc, 32'd20);
      tick(8);
      chk("lu_sw_x1", ram[4], 32'd5);
      chk("lu_x4", ram[5], 32'd5);
      chk("lu_x5", ram[6], 32'd6);

      // byte and halfword lanes
      clear_imem();
      imem[0] = e_i(32'h80, 0, 0, 1, 7'h13);
      imem[1] = e_s(3, 1, 0, 0);
      imem[2] = e_i(3, 0, 0, 6, 7'h03);
      imem[3] = e_i(3, 0, 4, 7, 7'h03);
      imem[4] = e_s(2, 1, 0, 1);
      imem[5] = e_s(32, 6, 0, 2);
      imem[6] = e_s(36, 7, 0, 2);
      start();
      tick(4);
      chk("sb_write", 32'(mem_write), 32'h1);
      chk("sb_strb", 32'(mem_strb), 32'h8);
      chk("sb_data", mem_data, 32'h8080_8080);
      chk("sb_addr", mem_addr, 32'h0);
      tick(3);
      chk("sh_strb", 32'(mem_strb), 32'hC);
      chk("sh_data", mem_data, 32'h0080_0080);
      tick(8);
      chk("lb_x6", ram[8], 32'hFFFF_FF80);
      chk("lbu_x7", ram[9], 32'h0000_0080);
      chk("ram_word0", ram[0], 32'h0080_0000);

      // control flow with squashes
      clear_imem();
      imem[0]  = e_i(32'h100, 0, 0, 2, 7'h13);
      imem[8]  = e_b(8, 0, 0, 0);
      imem[9]  = e_i(1, 0, 0, 9, 7'h13);
      imem[10] = e_j(32'h18, 0);
      imem[11] = e_i(2, 0, 0, 9, 7'h13);
      imem[12] = e_s(40, 1, 0, 2);
      imem[13] = e_i(1, 2, 0, 0, 7'h67);
      imem[14] = e_i(3, 0, 0, 9, 7'h13);
      imem[16] = e_j(-16, 1);
      imem[17] = e_i(4, 0, 0, 9, 7'h13);
      imem[64] = e_s(44, 9, 0, 2);
      start();
      tick(8);
      chk("br_pc_20", pc, 32'h20);
      tick(1);
      chk("br_pc_24", pc, 32'h24);
      tick(1);
      chk("br_pc_28", pc, 32'h28);
      tick(2);
      chk("jal_pc_40", pc, 32'h40);
      tick(2);
      chk("jal_pc_30", pc, 32'h30);
      tick(3);
      chk("jalr_pc", pc, 32'h100);
      tick(8);
      chk("jal_link", ram[10], 32'h44);
      chk("squash_x9", ram[11], 32'h0);

      // ALU modes
      clear_imem();
      imem[0]  = {20'h80000, 5'd1, 7'h37};
      imem[1]  = e_i(4, 0, 0, 2, 7'h13);
      imem[2]  = e_r(32'h20, 2, 1, 5, 3);
      imem[3]  = e_r(0, 2, 1, 5, 6);
      imem[4]  = e_r(32'h20, 1, 2, 0, 4);
      imem[5]  = e_r(0, 2, 1, 2, 5);
      imem[6]  = e_r(0, 2, 1, 3, 7);
      imem[7]  = e_i(32'h404, 1, 5, 8, 7'h13);
      imem[8]  = e_i(-1024, 1, 0, 10, 7'h13);
      imem[9]  = e_s(48, 3, 0, 2);
      imem[10] = e_s(52, 6, 0, 2);
      imem[11] = e_s(56, 4, 0, 2);
      imem[12] = e_s(60, 5, 0, 2);
      imem[13] = e_s(64, 7, 0, 2);
      imem[14] = e_s(68, 8, 0, 2);
      imem[15] = e_s(72, 10, 0, 2);
      start();
      tick(24);
      chk("sra", ram[12], 32'hF800_0000);
      chk("srl", ram[13], 32'h0800_0000);
      chk("sub", ram[14], 32'h8000_0004);
      chk("slt", ram[15], 32'h1);
      chk("sltu", ram[16], 32'h0);
      chk("srai", ram[17], 32'hF800_0000);
      chk("addi_b30", ram[18], 32'h7FFF_FC00);

      // reset with a store in MA
      clear_imem();
      imem[0] = e_i(7, 0, 0, 1, 7'h13);
      imem[1] = e_s(76, 1, 0, 2);
      start();
      tick(3);
      rst = 1'b1;
      clear_imem();
      tick(1);
      chk("midrst_pc", pc, 32'h0);
      chk("midrst_wr", 32'(mem_write), 32'h0);
      chk("midrst_strb", 32'(mem_strb), 32'h0);
      rst = 1'b0;
      chk("rel_pc", pc, 32'h0);
      wr_seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         wr_seen = wr_seen | mem_write;
         tick(1);
      end
      chk("rel_no_write", 32'(wr_seen), 32'h0);
      chk("rel_ram", ram[19], 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
